// File: rtl/rx_frame_receiver.sv
// rx_frame_receiver
//   UART-style receive front end. The raw serial line is synchronised,
//   a falling edge while idle starts a frame, the start bit is re-checked
//   at mid-bit, eight data bits are sampled LSB-first at mid-bit and the
//   stop bit is checked one bit period after the last data sample. A good
//   frame is handed to the RX buffer with a one-cycle strobe; a bad stop
//   bit raises framing_error and the byte is dropped.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (4..1023)
//
// Ports
//   clk            system clock, rising edge
//   n_rst          asynchronous active-low reset
//   serial_in      raw asynchronous serial line, idle high
//   packet_data    last correctly framed byte
//   load_buffer    one-cycle strobe: packet_data valid for the buffer
//   framing_error  last evaluated frame had a 0 stop bit
//   rx_busy        high while a frame is in progress
module rx_frame_receiver #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       serial_in,
  output logic [7:0] packet_data,
  output logic       load_buffer,
  output logic       framing_error,
  output logic       rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  // Terminal counts: the start bit is checked half a period after the
  // edge, every later sample one full period after the previous one.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic             sync_meta;
  logic             sync;
  logic             prev;
  logic [1:0]       state;
  logic [CNT_W-1:0] period_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             start_edge;

  // Two-flop synchroniser plus edge register; all idle-high after reset so
  // releasing reset never looks like a start edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_meta <= 1'b1;
      sync      <= 1'b1;
      prev      <= 1'b1;
    end else begin
      sync_meta <= serial_in;
      sync      <= sync_meta;
      prev      <= sync;
    end
  end

  assign start_edge = prev & ~sync;
  assign rx_busy    = (state != IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      period_cnt    <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      packet_data   <= 8'hFF;
      load_buffer   <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      load_buffer <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state      <= START;
            period_cnt <= '0;
          end
        end

        START: begin
          if (period_cnt == HALF_LAST) begin
            period_cnt <= '0;
            bit_cnt    <= '0;
            // A line already back high at mid-bit was a glitch, not a start.
            state      <= sync ? IDLE : DATA;
          end else begin
            period_cnt <= period_cnt + 1'b1;
          end
        end

        DATA: begin
          if (period_cnt == FULL_LAST) begin
            period_cnt <= '0;
            // Shift in from the MSB side so the first (LSB) sample ends in bit 0.
            shift_reg  <= {sync, shift_reg[7:1]};
            bit_cnt    <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end
          end else begin
            period_cnt <= period_cnt + 1'b1;
          end
        end

        STOP: begin
          if (period_cnt == FULL_LAST) begin
            period_cnt <= '0;
            state      <= IDLE;
            if (sync) begin
              packet_data   <= shift_reg;
              load_buffer   <= 1'b1;
              framing_error <= 1'b0;
            end else begin
              framing_error <= 1'b1;
            end
          end else begin
            period_cnt <= period_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_receiver.sv
// tb_rx_frame_receiver
//   Drives per-cycle serial waveforms into two receiver instances
//   (CLKS_PER_BIT = 10 and 4) and compares every output on every cycle
//   against expectations derived from the frame rules: the synchronised
//   line is the driven line delayed two cycles, a frame starts where it
//   falls while idle, bits are read at fixed offsets from that point.
module tb_rx_frame_receiver;

  localparam int MAXN = 4096;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       si10 = 1'b1;
  logic       si4 = 1'b1;
  logic [7:0] pd10, pd4;
  logic       ld10, ld4, fe10, fe4, bz10, bz4;

  always #5 clk = ~clk;

  rx_frame_receiver #(.CLKS_PER_BIT(10)) dut10 (
    .clk(clk), .n_rst(n_rst), .serial_in(si10),
    .packet_data(pd10), .load_buffer(ld10),
    .framing_error(fe10), .rx_busy(bz10)
  );

  rx_frame_receiver #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .serial_in(si4),
    .packet_data(pd4), .load_buffer(ld4),
    .framing_error(fe4), .rx_busy(bz4)
  );

  int checks = 0;
  int errors = 0;

  bit         line_q[$];
  int         strobe_t[$];
  bit         exp_load[MAXN];
  bit         exp_busy[MAXN];
  bit         exp_fe[MAXN];
  logic [7:0] exp_pd[MAXN];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input bit v, input int n);
    repeat (n) line_q.push_back(v);
  endtask

  task automatic put_frame(input logic [7:0] b, input bit stop_bit, input int cpb);
    put(1'b0, cpb);
    for (int i = 0; i < 8; i++) put(b[i], cpb);
    put(stop_bit, cpb);
  endtask

  // Synchronised line value seen by the receiver in cycle i.
  function automatic bit s_at(input int i);
    if (i < 2) return 1'b1;
    if (i - 2 >= line_q.size()) return 1'b1;
    return line_q[i - 2];
  endfunction

  function automatic void build_model(input int cpb);
    int         n;
    int         h;
    int         c;
    int         t0;
    int         ts;
    logic [7:0] b;
    logic [7:0] pd;
    bit         fe;
    bit         upd[MAXN];
    bit         good[MAXN];
    logic [7:0] val[MAXN];
    n = line_q.size();
    h = cpb / 2;
    for (int i = 0; i < n; i++) begin
      exp_load[i] = 1'b0;
      exp_busy[i] = 1'b0;
      upd[i]      = 1'b0;
      good[i]     = 1'b0;
      val[i]      = 8'h00;
    end
    c = 1;
    while (c < n) begin
      if (s_at(c - 1) && !s_at(c)) begin
        t0 = c;
        if (s_at(t0 + h)) begin
          for (int k = t0 + 1; k <= t0 + h && k < n; k++) exp_busy[k] = 1'b1;
          c = t0 + h + 1;
        end else begin
          for (int k = 1; k <= 8; k++) b[k - 1] = s_at(t0 + h + k * cpb);
          ts = t0 + h + 9 * cpb;
          for (int k = t0 + 1; k <= ts && k < n; k++) exp_busy[k] = 1'b1;
          if (ts + 1 < n) begin
            upd[ts + 1]  = 1'b1;
            good[ts + 1] = s_at(ts);
            val[ts + 1]  = b;
          end
          c = ts + 1;
        end
      end else begin
        c++;
      end
    end
    pd = 8'hFF;
    fe = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (upd[i]) begin
        if (good[i]) begin
          pd          = val[i];
          fe          = 1'b0;
          exp_load[i] = 1'b1;
        end else begin
          fe = 1'b1;
        end
      end
      exp_pd[i] = pd;
      exp_fe[i] = fe;
    end
  endfunction

  // Assert reset, confirm every output of both instances is at its reset
  // value without waiting for a clock, then release with the line idle.
  task automatic do_reset();
    @(negedge clk);
    si10  = 1'b1;
    si4   = 1'b1;
    n_rst = 1'b0;
    #1;
    check("rst pd10", pd10, 8'hFF);
    check("rst ld10", ld10, 1'b0);
    check("rst fe10", fe10, 1'b0);
    check("rst bz10", bz10, 1'b0);
    check("rst pd4", pd4, 8'hFF);
    check("rst ld4", ld4, 1'b0);
    check("rst fe4", fe4, 1'b0);
    check("rst bz4", bz4, 1'b0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Play line_q into the selected instance one value per cycle and compare
  // that cycle's outputs first. Stops early (before checking) at abort_at.
  task automatic run_scn(input int sel, input int abort_at, input string name);
    int         n;
    logic [7:0] o_pd;
    logic       o_ld, o_fe, o_bz;
    n = line_q.size();
    if (n > MAXN) begin
      $display("FAIL %s: waveform length %0d exceeds %0d", name, n, MAXN);
      $fatal(1, "waveform too long");
    end
    build_model(sel ? 4 : 10);
    strobe_t.delete();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == abort_at) return;
      o_pd = sel ? pd4 : pd10;
      o_ld = sel ? ld4 : ld10;
      o_fe = sel ? fe4 : fe10;
      o_bz = sel ? bz4 : bz10;
      if (o_ld === 1'b1) strobe_t.push_back(c);
      check($sformatf("%s c%0d load_buffer", name, c), o_ld, exp_load[c]);
      check($sformatf("%s c%0d packet_data", name, c), o_pd, exp_pd[c]);
      check($sformatf("%s c%0d framing_error", name, c), o_fe, exp_fe[c]);
      check($sformatf("%s c%0d rx_busy", name, c), o_bz, exp_busy[c]);
      if (sel != 0) si4 = line_q[c];
      else          si10 = line_q[c];
    end
    @(negedge clk);
    si10 = 1'b1;
    si4  = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    do_reset();

    // Valid 0xA5 frame.
    line_q.delete();
    put(1'b1, 5);
    put_frame(8'hA5, 1'b1, 10);
    put(1'b1, 30);
    run_scn(0, -1, "a5");
    check("a5 strobe count", strobe_t.size(), 1);

    // Bad stop bit on 0x3C, then a good 0x81.
    do_reset();
    line_q.delete();
    put(1'b1, 5);
    put_frame(8'h3C, 1'b0, 10);
    put(1'b1, 20);
    put_frame(8'h81, 1'b1, 10);
    put(1'b1, 30);
    run_scn(0, -1, "ferr");
    check("ferr strobe count", strobe_t.size(), 1);

    // Three-cycle low pulse: false start.
    do_reset();
    line_q.delete();
    put(1'b1, 5);
    put(1'b0, 3);
    put(1'b1, 40);
    run_scn(0, -1, "glitch");
    check("glitch strobe count", strobe_t.size(), 0);

    // Back-to-back 0x00 then 0xFF, no idle between stop and next start.
    do_reset();
    line_q.delete();
    put(1'b1, 5);
    put_frame(8'h00, 1'b1, 10);
    put_frame(8'hFF, 1'b1, 10);
    put(1'b1, 30);
    run_scn(0, -1, "b2b");
    check("b2b strobe count", strobe_t.size(), 2);
    gap = (strobe_t.size() >= 2) ? strobe_t[1] - strobe_t[0] : -1;
    check("b2b strobe spacing", gap, 100);

    // Good frame, bad-stop frame, then reset during data bit 4 of a third.
    do_reset();
    line_q.delete();
    put_frame(8'h42, 1'b1, 10);
    put(1'b1, 10);
    put_frame(8'h99, 1'b0, 10);
    put(1'b1, 10);
    put_frame(8'h11, 1'b1, 10);
    put(1'b1, 30);
    run_scn(0, 220 + 55, "abort");
    do_reset();
    line_q.delete();
    put(1'b1, 5);
    put_frame(8'h5A, 1'b1, 10);
    put(1'b1, 30);
    run_scn(0, -1, "after_abort");
    check("after_abort strobe count", strobe_t.size(), 1);

    // Short bit period instance, 0x96.
    do_reset();
    line_q.delete();
    put(1'b1, 5);
    put_frame(8'h96, 1'b1, 4);
    put(1'b1, 20);
    run_scn(1, -1, "cpb4_96");
    check("cpb4_96 strobe count", strobe_t.size(), 1);

    // Random frames, random stop bits, random gaps and occasional glitches.
    do_reset();
    line_q.delete();
    put(1'b1, 5);
    for (int f = 0; f < 12; f++) begin
      if ($urandom_range(0, 4) == 0) begin
        put(1'b0, $urandom_range(1, 4));
        put(1'b1, $urandom_range(6, 12));
      end
      put_frame(8'($urandom), ($urandom_range(0, 3) != 0), 10);
      put(1'b1, $urandom_range(0, 6));
    end
    put(1'b1, 30);
    run_scn(0, -1, "rand10");

    // Random frames on the short-period instance with scattered line flips.
    do_reset();
    line_q.delete();
    put(1'b1, 5);
    for (int f = 0; f < 20; f++) begin
      put_frame(8'($urandom), ($urandom_range(0, 3) != 0), 4);
      put(1'b1, $urandom_range(0, 5));
    end
    for (int i = 5; i < line_q.size(); i++) begin
      if ($urandom_range(0, 49) == 0) line_q[i] = ~line_q[i];
    end
    put(1'b1, 30);
    run_scn(1, -1, "rand4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
